calc3_rr_alu: RTL and testbench
===============================

Name: calc3_rr_alu

Overview:
Parametrised successor to the four-port calc2 calculator. NUM_PORTS requesters each submit two-cycle tagged commands into a per-port FIFO. A round-robin arbiter issues one queued command per cycle to a single shared registered ALU, and the result is returned on the originating port's response bus with its tag. New relative to calc2: per-port queuing with ready backpressure, parametrised width, port count and depth, and fair arbitration.

Parameters:
NUM_PORTS, 4, number of request/response port pairs (2..8)
DATA_W, 32, operand and result width (8..64, power of 2)
TAG_W, 2, tag width
FIFO_DEPTH, 4, entries per port queue (power of 2, >=2)

Ports:
c_clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_cmd_in  input  NUM_PORTS*4  per-port command; port p occupies bits [4p+3:4p]
req_data_in  input  NUM_PORTS*DATA_W  per-port operand
req_tag_in  input  NUM_PORTS*TAG_W  per-port tag, sampled in the command cycle
req_ready  output  NUM_PORTS  per-port: queue can accept a new command (registered)
out_resp  output  NUM_PORTS*2  per-port response: 0 none, 1 success, 2 error
out_data  output  NUM_PORTS*DATA_W  per-port result
out_tag  output  NUM_PORTS*TAG_W  per-port tag echoed with the response

Behaviour:
- All state updates on posedge c_clk. Reset is synchronous, active-high, and takes priority over everything else.
- While reset is sampled high: out_resp/out_data/out_tag=0, req_ready=0. All queues are flushed, the ALU stage is cleared, the RR pointer is set to 0 and any half-received request is discarded. req_ready=1 from the first cycle after reset is sampled low.
- Request protocol, per port:
  - Cycle A: cmd!=0, data=op1, tag.
  - Cycle A+1 (B): data=op2; cmd in B is ignored.
  - Cycle A is accepted only if req_ready=1 in that cycle. Otherwise the request is silently dropped and produces no response.
  - cmd=0 outside phase B means idle.
- Per-port receive FSM:
  - IDLE: on cmd!=0 and ready, latch cmd/op1/tag, go to OP2.
  - OP2: latch op2, push {cmd,op1,op2,tag} into the queue at the end of B, return to IDLE.
  - Maximum accept rate: one request per 2 cycles per port.
- Queue: FIFO_DEPTH entries, count 0..FIFO_DEPTH.
  - req_ready = (count + pending_in_OP2) < FIFO_DEPTH, so the entry captured in cycle A is always guaranteed a slot in B.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Arbiter:
  - Each cycle, grant the first non-empty queue scanning from rr_ptr upward, modulo NUM_PORTS, then set rr_ptr = grant+1.
  - No grant means rr_ptr is unchanged.
  - Exactly one pop per cycle maximum.
- ALU, registered:
  - The granted entry is computed and its result drives the owning port's out_* at the next edge.
  - Latency: if B is cycle T and the port wins grant immediately at T+1, the response is visible at T+2.
  - The response is held exactly one cycle, then out_resp/out_data/out_tag return to 0.
- Commands:
  - 4'h1 ADD: op1+op2. A carry out of DATA_W gives resp=2, data=0.
  - 4'h2 SUB: op1-op2. op2>op1 gives resp=2, data=0.
  - 4'h5 SHL: op1 << op2[log2(DATA_W)-1:0], resp=1, zero fill.
  - 4'h6 SHR: op1 >> op2[log2(DATA_W)-1:0], resp=1, zero fill.
  - Any other nonzero cmd: resp=2, data=0, tag echoed.
- Ordering and tags:
  - Responses within one port are returned in acceptance order.
  - Across ports, order follows grant order.
  - Tags are not checked for uniqueness.

Test Plan:
1. Port 0, reset released: cmd=1, op1=0x30, tag=1, then op2=0x20. Required: out_resp[0]=1, out_data[0]=0x50, out_tag[0]=1 exactly 2 cycles after the op2 cycle, and 0 on the following cycle.
2. Error cases on port 2:
   - ADD 0xFFFFFFFF+1 -> resp=2, data=0.
   - SUB 5-6 -> resp=2, data=0.
   - cmd 4'h3 -> resp=2, data=0.
   - SHL 1 by 31 -> 0x80000000, resp=1.
   - SHR 0x80000000 by 0x23 -> 0x10000000, resp=1 (amount 3).
3. All four ports issue ADD in the same cycle with tags 0..3. Required: responses on ports 0, 1, 2, 3 in four consecutive cycles. A repeat of the test with rr_ptr=2 yields order 2, 3, 0, 1.
4. All ports issue requests every 2 cycles for 40 cycles.
   - req_ready deasserts on at least one port.
   - Commands issued while req_ready=0 get no response.
   - Every accepted request responds exactly once, in per-port order, with the correct tag and result.
5. Three ports hold full queues while reset is asserted for 1 cycle. Required: all out_* = 0 and req_ready=0 during reset, then no stale responses ever appear, and req_ready=1 on the next cycle.
6. Port 1 issues cmd=1 in cycle A and cmd=2 in its B cycle, with op2=7. Required: the B-cycle cmd is ignored, and exactly one ADD response is produced using op2=7.

Source files
------------

// File: rtl/calc3_rr_alu.sv
// rtl/calc3_rr_alu.sv - NUM_PORTS-port tagged calculator: per-port queues, round-robin arbiter, shared registered ALU
// Two-cycle requests are captured per port, queued, and served one per cycle in round-robin order.
module calc3_rr_alu #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*4-1:0]        req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
  input  logic [NUM_PORTS*TAG_W-1:0]    req_tag_in,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS*2-1:0]        out_resp,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [NUM_PORTS*TAG_W-1:0]    out_tag
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(DATA_W);

  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_SHL = 4'h5;
  localparam logic [3:0] CMD_SHR = 4'h6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_OP2  = 1'b1
  } rx_state_t;

  logic [NUM_PORTS-1:0]             not_empty;
  logic [NUM_PORTS-1:0]             pop;
  logic [NUM_PORTS-1:0][3:0]        head_cmd;
  logic [NUM_PORTS-1:0][DATA_W-1:0] head_op1;
  logic [NUM_PORTS-1:0][DATA_W-1:0] head_op2;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  head_tag;

  logic          grant_valid;
  logic [PW-1:0] grant;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_next;
  logic [PW-1:0] scan_idx;
  int            scan;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      rx_state_t          state_q, state_d;
      logic [3:0]         cmd_in;
      logic [DATA_W-1:0]  data_in;
      logic [TAG_W-1:0]   tag_in;
      logic [3:0]         cmd_q;
      logic [DATA_W-1:0]  op1_q;
      logic [TAG_W-1:0]   tag_q;
      logic               accept;
      logic               push;
      logic               ready_q;
      logic [3:0]         f_cmd [FIFO_DEPTH];
      logic [DATA_W-1:0]  f_op1 [FIFO_DEPTH];
      logic [DATA_W-1:0]  f_op2 [FIFO_DEPTH];
      logic [TAG_W-1:0]   f_tag [FIFO_DEPTH];
      logic [AW-1:0]      wr_ptr, rd_ptr;
      logic [CW-1:0]      count, count_d;
      logic [CW:0]        occupancy_d;

      assign cmd_in  = req_cmd_in[4*p +: 4];
      assign data_in = req_data_in[DATA_W*p +: DATA_W];
      assign tag_in  = req_tag_in[TAG_W*p +: TAG_W];

      always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        push    = 1'b0;
        case (state_q)
          RX_IDLE: begin
            if (cmd_in != 4'h0 && ready_q) begin
              accept  = 1'b1;
              state_d = RX_OP2;
            end
          end
          RX_OP2: begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end
          default: state_d = RX_IDLE;
        endcase
      end

      always_comb begin
        count_d = count;
        case ({push, pop[p]})
          2'b10:   count_d = count + CW'(1);
          2'b01:   count_d = count - CW'(1);
          default: count_d = count;
        endcase
      end

      // A request sitting in OP2 already owns a slot, so it counts toward occupancy.
      assign occupancy_d = {1'b0, count_d} + {{CW{1'b0}}, (state_d == RX_OP2)};

      always_ff @(posedge c_clk) begin
        if (reset) begin
          state_q <= RX_IDLE;
          cmd_q   <= '0;
          op1_q   <= '0;
          tag_q   <= '0;
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          count   <= '0;
          ready_q <= 1'b0;
        end else begin
          state_q <= state_d;
          if (accept) begin
            cmd_q <= cmd_in;
            op1_q <= data_in;
            tag_q <= tag_in;
          end
          if (push)   wr_ptr <= wr_ptr + AW'(1);
          if (pop[p]) rd_ptr <= rd_ptr + AW'(1);
          count   <= count_d;
          ready_q <= occupancy_d < (CW + 1)'(FIFO_DEPTH);
        end
      end

      always_ff @(posedge c_clk) begin
        if (!reset && push) begin
          f_cmd[wr_ptr] <= cmd_q;
          f_op1[wr_ptr] <= op1_q;
          f_op2[wr_ptr] <= data_in;
          f_tag[wr_ptr] <= tag_q;
        end
      end

      assign req_ready[p] = ready_q;
      assign not_empty[p] = (count != '0);
      assign head_cmd[p]  = f_cmd[rd_ptr];
      assign head_op1[p]  = f_op1[rd_ptr];
      assign head_op2[p]  = f_op2[rd_ptr];
      assign head_tag[p]  = f_tag[rd_ptr];
    end
  endgenerate

  // First non-empty queue at or after rr_ptr, wrapping at NUM_PORTS.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    pop         = '0;
    scan        = 0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= NUM_PORTS) scan = scan - NUM_PORTS;
      scan_idx = PW'(scan);
      if (!grant_valid && not_empty[scan_idx]) begin
        grant_valid = 1'b1;
        grant       = scan_idx;
      end
    end
    if (grant_valid) pop[grant] = 1'b1;
  end

  always_comb begin
    rr_next = rr_ptr;
    if (grant_valid) begin
      if (grant == PW'(NUM_PORTS - 1)) rr_next = '0;
      else                             rr_next = grant + PW'(1);
    end
  end

  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [TAG_W-1:0]  alu_tag;
  logic [DATA_W:0]   add_full;
  logic [1:0]        alu_resp;
  logic [DATA_W-1:0] alu_data;

  assign alu_cmd  = head_cmd[grant];
  assign alu_a    = head_op1[grant];
  assign alu_b    = head_op2[grant];
  assign alu_tag  = head_tag[grant];
  assign add_full = {1'b0, alu_a} + {1'b0, alu_b};

  always_comb begin
    alu_resp = RESP_ERR;
    alu_data = '0;
    case (alu_cmd)
      CMD_ADD: begin
        if (!add_full[DATA_W]) begin
          alu_resp = RESP_OK;
          alu_data = add_full[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (alu_b <= alu_a) begin
          alu_resp = RESP_OK;
          alu_data = alu_a - alu_b;
        end
      end
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = alu_a << alu_b[SW-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = alu_a >> alu_b[SW-1:0];
      end
      default: begin
        alu_resp = RESP_ERR;
        alu_data = '0;
      end
    endcase
  end

  // Responses live for exactly one cycle; every other port reads zero.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
      rr_ptr   <= '0;
    end else begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
      rr_ptr   <= rr_next;
      if (grant_valid) begin
        out_resp[2*int'(grant) +: 2]           <= alu_resp;
        out_data[DATA_W*int'(grant) +: DATA_W] <= alu_data;
        out_tag[TAG_W*int'(grant) +: TAG_W]    <= alu_tag;
      end
    end
  end

endmodule

// File: tb/tb_calc3_rr_alu.sv
// tb/tb_calc3_rr_alu.sv - self-checking bench for calc3_rr_alu
module tb_calc3_rr_alu;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int FD = 4;

  logic              c_clk = 1'b0;
  logic              reset;
  logic [NP*4-1:0]   req_cmd_in;
  logic [NP*DW-1:0]  req_data_in;
  logic [NP*TW-1:0]  req_tag_in;
  logic [NP-1:0]     req_ready;
  logic [NP*2-1:0]   out_resp;
  logic [NP*DW-1:0]  out_data;
  logic [NP*TW-1:0]  out_tag;

  calc3_rr_alu #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(FD)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready(req_ready), .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 c_clk = ~c_clk;

  typedef struct packed {
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } rsp_t;

  rsp_t exp_q [NP][$];
  int   log_port [$];
  int   log_cyc  [$];
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  int   n_acc  = 0;
  logic seen_block;

  logic [3:0]    a_cmd [NP];
  logic [3:0]    b_cmd [NP];
  logic [DW-1:0] a_op1 [NP];
  logic [DW-1:0] a_op2 [NP];
  logic [TW-1:0] a_tag [NP];
  logic          a_en  [NP];

  logic [3:0]    t2_cmd  [5] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6};
  logic [DW-1:0] t2_op1  [5] = '{32'hFFFF_FFFF, 32'd5, 32'd9, 32'd1, 32'h8000_0000};
  logic [DW-1:0] t2_op2  [5] = '{32'd1, 32'd6, 32'd4, 32'd31, 32'h23};
  logic [1:0]    t2_resp [5] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
  logic [DW-1:0] t2_data [5] = '{32'h0, 32'h0, 32'h0, 32'h8000_0000, 32'h1000_0000};
  int            ord2    [4] = '{2, 3, 0, 1};
  logic [3:0]    cmd_pool[6] = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h3, 4'hF};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic in wide unsigned integers.
  function automatic rsp_t model(input logic [3:0] cmd, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [TW-1:0] tag);
    longint unsigned ua, ub, lim;
    rsp_t o;
    ua = a; ub = b; lim = 64'd1 << DW;
    o.tag = tag; o.resp = 2'd2; o.data = '0;
    case (cmd)
      4'h1: if (ua + ub < lim) begin o.resp = 2'd1; o.data = DW'(ua + ub); end
      4'h2: if (ub <= ua) begin o.resp = 2'd1; o.data = DW'(ua - ub); end
      4'h5: begin o.resp = 2'd1; o.data = DW'(ua << (ub % DW)); end
      4'h6: begin o.resp = 2'd1; o.data = DW'(ua >> (ub % DW)); end
      default: ;
    endcase
    return o;
  endfunction

  task automatic cycle();
    logic [1:0] r;
    rsp_t       e;
    @(posedge c_clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      r = out_resp[2*p +: 2];
      if (r != 2'd0) begin
        log_port.push_back(p);
        log_cyc.push_back(cyc);
        if (exp_q[p].size() == 0) begin
          check($sformatf("unexpected_resp_p%0d", p), 64'(r), 64'd0);
        end else begin
          e = exp_q[p].pop_front();
          check($sformatf("resp_p%0d", p),
                64'({r, out_data[DW*p +: DW], out_tag[TW*p +: TW]}), 64'(e));
        end
      end
    end
  endtask

  task automatic drain(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_en();
    for (int p = 0; p < NP; p++) begin
      a_en[p] = 1'b0; b_cmd[p] = 4'h0; a_cmd[p] = 4'h0;
      a_op1[p] = '0; a_op2[p] = '0; a_tag[p] = '0;
    end
  endtask

  // Phase A now, phase B next cycle; returns one cycle after B.
  task automatic send_pair();
    for (int p = 0; p < NP; p++) begin
      if (a_en[p]) begin
        req_cmd_in[4*p +: 4]    = a_cmd[p];
        req_data_in[DW*p +: DW] = a_op1[p];
        req_tag_in[TW*p +: TW]  = a_tag[p];
        if (req_ready[p]) begin
          exp_q[p].push_back(model(a_cmd[p], a_op1[p], a_op2[p], a_tag[p]));
          n_acc++;
        end else begin
          seen_block = 1'b1;
        end
      end else begin
        req_cmd_in[4*p +: 4] = 4'h0;
      end
    end
    cycle();
    for (int p = 0; p < NP; p++) begin
      if (a_en[p]) begin
        req_cmd_in[4*p +: 4]    = b_cmd[p];
        req_data_in[DW*p +: DW] = a_op2[p];
      end
    end
    cycle();
    req_cmd_in = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    req_cmd_in = '0; req_data_in = '0; req_tag_in = '0;
    seen_block = 1'b0;
    clear_en();
    drain(3);
    check("rst_resp", 64'(out_resp), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    cycle();
    check("ready_after_reset", 64'(req_ready), 64'hF);

    // Basic ADD latency and one-cycle hold
    clear_en();
    a_en[0] = 1'b1; a_cmd[0] = 4'h1; a_op1[0] = 32'h30; a_op2[0] = 32'h20; a_tag[0] = 2'd1;
    send_pair();
    check("t1_resp_T+1", 64'(out_resp[1:0]), 64'd0);
    cycle();
    check("t1_resp_T+2", 64'(out_resp[1:0]), 64'd1);
    check("t1_data_T+2", 64'(out_data[31:0]), 64'h50);
    check("t1_tag_T+2", 64'(out_tag[1:0]), 64'd1);
    cycle();
    check("t1_resp_T+3", 64'(out_resp[1:0]), 64'd0);
    check("t1_data_T+3", 64'(out_data[31:0]), 64'd0);

    // Error and shift cases on port 2
    for (int i = 0; i < 5; i++) begin
      clear_en();
      a_en[2] = 1'b1; a_cmd[2] = t2_cmd[i]; a_op1[2] = t2_op1[i];
      a_op2[2] = t2_op2[i]; a_tag[2] = TW'(i);
      send_pair();
      cycle();
      check($sformatf("t2_resp_%0d", i), 64'(out_resp[5:4]), 64'(t2_resp[i]));
      check($sformatf("t2_data_%0d", i), 64'(out_data[95:64]), 64'(t2_data[i]));
      drain(2);
    end

    // Simultaneous requests: grant order from rr_ptr=0, then from rr_ptr=2
    pulse_reset();
    clear_en();
    log_port.delete(); log_cyc.delete();
    for (int p = 0; p < NP; p++) begin
      a_en[p] = 1'b1; a_cmd[p] = 4'h1; a_op1[p] = $urandom_range(0, 1000);
      a_op2[p] = $urandom_range(0, 1000); a_tag[p] = TW'(p);
    end
    send_pair();
    drain(6);
    check("t3_count", 64'(log_port.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_port.size(); i++) begin
      check($sformatf("t3_port_%0d", i), 64'(log_port[i]), 64'(i));
      check($sformatf("t3_cyc_%0d", i), 64'(log_cyc[i] - log_cyc[0]), 64'(i));
    end
    clear_en();
    a_en[1] = 1'b1; a_cmd[1] = 4'h6; a_op1[1] = $urandom; a_op2[1] = $urandom; a_tag[1] = 2'd2;
    send_pair();
    drain(4);
    log_port.delete(); log_cyc.delete();
    for (int p = 0; p < NP; p++) begin
      a_en[p] = 1'b1; a_cmd[p] = 4'h1; a_op1[p] = $urandom_range(0, 1000);
      a_op2[p] = $urandom_range(0, 1000); a_tag[p] = TW'(p);
    end
    send_pair();
    drain(6);
    check("t3b_count", 64'(log_port.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_port.size(); i++) begin
      check($sformatf("t3b_port_%0d", i), 64'(log_port[i]), 64'(ord2[i]));
      check($sformatf("t3b_cyc_%0d", i), 64'(log_cyc[i] - log_cyc[0]), 64'(i));
    end

    // Saturating random traffic on all ports
    seen_block = 1'b0;
    n_acc = 0;
    log_port.delete(); log_cyc.delete();
    for (int r = 0; r < 20; r++) begin
      clear_en();
      for (int p = 0; p < NP; p++) begin
        a_en[p]  = 1'b1;
        a_cmd[p] = cmd_pool[$urandom_range(0, 5)];
        a_op1[p] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 255);
        a_op2[p] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 255);
        a_tag[p] = TW'($urandom_range(0, 3));
      end
      send_pair();
    end
    drain(30);
    check("t4_saw_backpressure", 64'(seen_block), 64'd1);
    check("t4_resp_count", 64'(log_port.size()), 64'(n_acc));
    for (int p = 0; p < NP; p++)
      check($sformatf("t4_drained_p%0d", p), 64'(exp_q[p].size()), 64'd0);

    // Reset with full queues on three ports
    seen_block = 1'b0;
    for (int r = 0; r < 16; r++) begin
      clear_en();
      for (int p = 0; p < 3; p++) begin
        a_en[p] = 1'b1; a_cmd[p] = 4'h1; a_op1[p] = $urandom_range(0, 99);
        a_op2[p] = $urandom_range(0, 99); a_tag[p] = TW'(p);
      end
      send_pair();
    end
    check("t5_saw_full", 64'(seen_block), 64'd1);
    reset = 1'b1;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    cycle();
    check("t5_rst_resp", 64'(out_resp), 64'd0);
    check("t5_rst_data", 64'(out_data), 64'd0);
    check("t5_rst_tag", 64'(out_tag), 64'd0);
    check("t5_rst_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    log_port.delete(); log_cyc.delete();
    cycle();
    check("t5_ready_after", 64'(req_ready), 64'hF);
    drain(20);
    check("t5_no_stale", 64'(log_port.size()), 64'd0);

    // Command in the B cycle is ignored
    clear_en();
    log_port.delete(); log_cyc.delete();
    a_en[1] = 1'b1; a_cmd[1] = 4'h1; b_cmd[1] = 4'h2;
    a_op1[1] = $urandom_range(0, 32'h7FFF_FFFF); a_op2[1] = 32'd7; a_tag[1] = 2'd3;
    send_pair();
    drain(4);
    check("t6_count", 64'(log_port.size()), 64'd1);
    check("t6_drained", 64'(exp_q[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
